// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port RAM with ack timeout.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; the default is fixed priority (data wins).
module mem_arbiter #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,

    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,

    output logic [XLEN-1:0] rdata_o,
    output logic            err_o,

    output logic            ram_req_o,
    output logic            ram_we_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_wdata_o,
    input  logic [XLEN-1:0] ram_rdata_i,
    input  logic            ram_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       owner_dm;
    logic       pick_dm;
    logic       idle_ok;

`ifdef MEM_ARBITER_RR_EN
    logic       last_dm;
`endif

    always_comb begin
        pick_dm = dm_req_i;
`ifdef MEM_ARBITER_RR_EN
        // On a tie the requester that did not own the previous grant wins.
        if (dm_req_i && if_req_i) begin
            pick_dm = !last_dm;
        end
`endif
    end

    // Grants are combinational and forced low while reset is held.
    assign idle_ok  = (state == IDLE) && !rst_i;
    assign dm_gnt_o = idle_ok && dm_req_i && pick_dm;
    assign if_gnt_o = idle_ok && if_req_i && !pick_dm;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_dm    <= 1'b0;
            if_rvalid_o <= 1'b0;
            dm_rvalid_o <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_dm     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dm_gnt_o || if_gnt_o) begin
                        owner_dm    <= dm_gnt_o;
                        ram_we_o    <= dm_gnt_o && dm_we_i;
                        ram_addr_o  <= dm_gnt_o ? dm_addr_i : if_addr_i;
                        ram_wdata_o <= dm_gnt_o ? dm_wdata_i : '0;
                        ram_req_o   <= 1'b1;
                        cnt         <= '0;
                        state       <= BUSY;
`ifdef MEM_ARBITER_RR_EN
                        last_dm     <= dm_gnt_o;
`endif
                    end
                end

                BUSY: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (ram_ack_i) begin
                        ram_req_o   <= 1'b0;
                        rdata_o     <= ram_we_o ? '0 : ram_rdata_i;
                        err_o       <= 1'b0;
                        dm_rvalid_o <= owner_dm;
                        if_rvalid_o <= !owner_dm;
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        ram_req_o   <= 1'b0;
                        rdata_o     <= '0;
                        err_o       <= 1'b1;
                        dm_rvalid_o <= owner_dm;
                        if_rvalid_o <= !owner_dm;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                RESP: begin
                    dm_rvalid_o <= 1'b0;
                    if_rvalid_o <= 1'b0;
                    err_o       <= 1'b0;
                    cnt         <= '0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter (XLEN=64, TIMEOUT=16); tie order follows MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;
    logic            ram_req;
    logic            ram_we;
    logic [XLEN-1:0] ram_addr;
    logic [XLEN-1:0] ram_wdata;
    logic [XLEN-1:0] ram_rdata;
    logic            ram_ack;

    int vectors     = 0;
    int miscompares = 0;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_gnt_o    (dm_gnt),
        .dm_rvalid_o (dm_rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .ram_req_o   (ram_req),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .ram_ack_i   (ram_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"},    {62'd0, if_gnt, dm_gnt}, 64'd0);
        check({tag, " rvalid"}, {62'd0, if_rvalid, dm_rvalid}, 64'd0);
        check({tag, " err"},    {63'd0, err}, 64'd0);
        check({tag, " ramreq"}, {62'd0, ram_req, ram_we}, 64'd0);
        check({tag, " ramaddr"}, ram_addr, 64'd0);
        check({tag, " ramwdat"}, ram_wdata, 64'd0);
        check({tag, " rdata"},   rdata, 64'd0);
    endtask

    logic exp_dm [4];
    int   ram_cycles;

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        ram_rdata = '0;
        ram_ack   = 1'b0;

        // Reset state, with a request pending that must not be granted.
        tick();
        if_req = 1'b1;
        #1;
        check_all_zero("reset");
        tick();

        // Single fetch; grant on the first edge after reset release.
        rst     = 1'b0;
        if_addr = 64'h100;
        #1;
        check("fetch gnt", {62'd0, if_gnt, dm_gnt}, 64'd2);
        tick();
        if_req    = 1'b0;
        ram_ack   = 1'b1;
        ram_rdata = 64'hDEAD;
        check("fetch ramreq", {62'd0, ram_req, ram_we}, 64'd2);
        check("fetch ramaddr", ram_addr, 64'h100);
        tick();
        ram_ack = 1'b0;
        check("fetch rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd2);
        check("fetch rdata", rdata, 64'hDEAD);
        check("fetch err", {63'd0, err}, 64'd0);
        tick();
        check("fetch idle rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
        check("rdata hold", rdata, 64'hDEAD);

        // Store with a 3-cycle ack delay; write data must be stable and rdata forced to 0.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 64'h2000;
        dm_wdata = 64'h1234;
        #1;
        check("store gnt", {62'd0, if_gnt, dm_gnt}, 64'd1);
        tick();
        dm_req   = 1'b0;
        dm_addr  = 64'h5555;
        dm_wdata = 64'h6666;
        for (int k = 0; k < 3; k++) begin
            check("store ramreq", {62'd0, ram_req, ram_we}, 64'd3);
            check("store ramaddr", ram_addr, 64'h2000);
            check("store ramwdat", ram_wdata, 64'h1234);
            if (k == 2) begin
                ram_ack   = 1'b1;
                ram_rdata = 64'hFFFF;
            end else begin
                tick();
            end
        end
        tick();
        check("store rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd1);
        check("store rdata", rdata, 64'd0);
        // Ack held high through RESP and IDLE must be ignored.
        tick();
        tick();
        ram_ack = 1'b0;
        check("stray ack", {61'd0, ram_req, if_rvalid, dm_rvalid}, 64'd0);

        // Contention from reset so the round-robin flag starts at fetch.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        dm_we  = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        exp_dm = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        dm_req = 1'b1;
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont gnt", {62'd0, if_gnt, dm_gnt}, exp_dm[i] ? 64'd1 : 64'd2);
            tick();
            ram_ack   = 1'b1;
            ram_rdata = 64'(i + 10);
            tick();
            ram_ack = 1'b0;
            check("cont rvalid", {62'd0, if_rvalid, dm_rvalid}, exp_dm[i] ? 64'd1 : 64'd2);
            check("cont rdata", rdata, 64'(i + 10));
            check("cont no gnt in resp", {62'd0, if_gnt, dm_gnt}, 64'd0);
            tick();
        end
        dm_req = 1'b0;

        // Timeout: ack never comes; fetch still pending from the contention loop.
        if_addr = 64'h300;
        #1;
        check("to gnt", {62'd0, if_gnt, dm_gnt}, 64'd2);
        tick();
        if_req     = 1'b0;
        ram_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (!ram_req) break;
            ram_cycles++;
            tick();
        end
        check("to ramreq cycles", 64'(ram_cycles), 64'd16);
        check("to rvalid err", {61'd0, if_rvalid, dm_rvalid, err}, 64'd5);
        check("to rdata", rdata, 64'd0);
        tick();
        check("to idle", {61'd0, if_rvalid, dm_rvalid, err}, 64'd0);

        // Ack on the 16th BUSY cycle beats the timeout.
        dm_req  = 1'b1;
        dm_addr = 64'h400;
        #1;
        check("ackto gnt", {62'd0, if_gnt, dm_gnt}, 64'd1);
        tick();
        dm_req = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        check("ackto ramreq", {63'd0, ram_req}, 64'd1);
        ram_ack   = 1'b1;
        ram_rdata = 64'hBEEF;
        tick();
        ram_ack = 1'b0;
        check("ackto rvalid err", {61'd0, if_rvalid, dm_rvalid, err}, 64'd2);
        check("ackto rdata", rdata, 64'hBEEF);
        tick();

        // Reset pulse in the middle of a load.
        dm_req  = 1'b1;
        dm_addr = 64'h500;
        #1;
        check("rst gnt", {62'd0, if_gnt, dm_gnt}, 64'd1);
        tick();
        dm_req = 1'b0;
        check("rst busy", {63'd0, ram_req}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst mid");
        tick();
        rst     = 1'b0;
        ram_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("rst no resp", {61'd0, if_rvalid, dm_rvalid, err}, 64'd0);
            tick();
        end
        ram_ack = 1'b0;
        if_req  = 1'b1;
        if_addr = 64'h600;
        #1;
        check("rst new gnt", {62'd0, if_gnt, dm_gnt}, 64'd2);
        tick();
        if_req = 1'b0;
        check("rst new addr", ram_addr, 64'h600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 64: address and data width.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles BUSY waits for ram_ack_i (valid range 2..255).
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 if_req_i  in  1  instruction-fetch read request, held until granted.
REQ-006 if_addr_i  in  XLEN  fetch address.
REQ-007 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid_o  out  1  one-cycle fetch response strobe.
REQ-009 dm_req_i  in  1  data request, held until granted.
REQ-010 dm_we_i  in  1  1=store, 0=load.
REQ-011 dm_addr_i, dm_wdata_i  in  XLEN each  data address and store data.
REQ-012 dm_gnt_o  out  1  data request accepted this cycle.
REQ-013 dm_rvalid_o  out  1  one-cycle data response strobe (load data or store completion).
REQ-014 rdata_o  out  XLEN  response data, shared by both requesters, qualified by the rvalid strobes.
REQ-015 err_o  out  1  one-cycle strobe with rvalid when the transaction timed out.
REQ-016 ram_req_o  out  1  RAM access strobe; ram_we_o  out  1; ram_addr_o, ram_wdata_o  out  XLEN.
REQ-017 ram_rdata_i  in  XLEN; ram_ack_i  in  1  RAM completion, valid only while ram_req_o=1.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-019 In IDLE with at least one request, the arbiter SHALL assert exactly one combinational grant, latch owner, we, addr and wdata, and go to BUSY next cycle.
REQ-020 Grants SHALL be asserted only in IDLE; a requester not granted keeps its request asserted.
REQ-021 In BUSY, ram_req_o SHALL be 1 and ram_we_o, ram_addr_o, ram_wdata_o SHALL hold the latched values, unchanged until exit.
REQ-022 On ram_ack_i=1 in BUSY, ram_rdata_i SHALL be registered (forced 0 for stores) and the FSM SHALL go to RESP.
REQ-023 A fetch grant SHALL always produce ram_we_o=0.
REQ-024 In RESP, only the owner's rvalid SHALL be 1 for one cycle with rdata_o valid; the FSM then returns to IDLE.
REQ-025 Minimum latency: grant in cycle N, ram_req_o in N+1, ack in N+1 gives rvalid in N+2; next grant no earlier than N+3.
REQ-026 A BUSY cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT-1 without ack, the FSM SHALL drop ram_req_o, go to RESP, and assert err_o with rvalid and rdata_o=0.
REQ-027 An ack arriving in the same cycle as the timeout SHALL take precedence, with err_o=0.
REQ-028 ram_ack_i outside BUSY SHALL be ignored.
REQ-029 rdata_o SHALL hold its last value when no rvalid is asserted.

Reset
REQ-030 With rst_i=1, the FSM SHALL be IDLE, the counter 0, and all outputs 0 (including rdata_o, ram_addr_o, ram_wdata_o), regardless of clock.
REQ-031 Reset during BUSY or RESP SHALL abandon the transaction with no rvalid or err pulse issued.
REQ-032 The first grant after reset deassertion SHALL be possible on the first rising edge with rst_i=0.

Configuration
REQ-033 Macro MEM_ARBITER_RR_EN undefined: fixed priority, where dm always wins over if on simultaneous requests.
REQ-034 Macro MEM_ARBITER_RR_EN defined: round-robin arbitration.
REQ-035 Under round-robin, a last-owner flag SHALL be set on each grant, and on simultaneous requests the requester that is not the last owner SHALL win.
REQ-036 Under round-robin, the last-owner flag SHALL reset to if, so dm wins the first tie.

Verification
REQ-037 Single fetch: if_req_i=1 with addr 0x100 and ack one cycle after ram_req_o with rdata 0xDEAD -> if_gnt_o in N, if_rvalid_o in N+2 with rdata_o=0xDEAD, dm_rvalid_o=0.
REQ-038 Store: dm_we_i=1 with addr 0x2000 and wdata 0x1234 -> ram_we_o=1, ram_addr_o=0x2000, ram_wdata_o=0x1234 stable until ack, then dm_rvalid_o=1 with rdata_o=0.
REQ-039 Contention: both requests held continuously for 4 transactions -> without macro, dm, dm, dm, dm; with MEM_ARBITER_RR_EN, dm, if, dm, if.
REQ-040 Timeout: TIMEOUT=16 with ack never asserted -> ram_req_o high exactly 16 cycles, then owner rvalid=1 and err_o=1 with rdata_o=0, then IDLE.
REQ-041 Reset mid-BUSY: rst_i pulsed for 1 cycle during a load -> all outputs 0 immediately, no rvalid afterwards, a new grant on the next request.
REQ-042 Ack on the timeout cycle (ack in the 16th BUSY cycle) -> rvalid=1 with ram data, err_o=0.
